// File: rtl/float_to_fix.sv
// float_to_fix: reads a float16 word from data memory, converts it to
// two's-complement fix(8.8) and writes the result back to data memory.
// The conversion truncates toward zero and saturates. Its magnitude is
// aligned by a serial shifter that moves one bit per cycle.
module float_to_fix #(
    parameter logic [7:0] SRC_ADDR = 8'd2,
    parameter logic [7:0] DST_ADDR = 8'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic [7:0]  DataAddress,
    output logic        WriteMem,
    output logic [7:0]  DataIn,
    input  logic [7:0]  DataOut,
    output logic [15:0] fix_out
);

    typedef enum logic [3:0] {
        IDLE, RD_LO, RD_HI, DECODE, SHIFT, FIX, WR_LO, WR_HI, DONE
    } state_t;

    state_t      state;
    logic        sign_r;
    logic [4:0]  exp_r;
    logic [9:0]  mant_r;
    logic [15:0] mag;
    logic [3:0]  cnt;
    logic        left_r;
    logic        sat_r;

    logic [3:0]  dec_k;
    logic        dec_left;
    logic        dec_zero;
    logic        dec_sat;
    logic [15:0] fix_val;

    // Saturate to the fix(8.8) limits, or negate the magnitude when the
    // sign bit is set. A negative zero wraps back to 0x0000.
    function automatic logic [15:0] sign_saturate(input logic neg,
                                                  input logic sat,
                                                  input logic [15:0] m);
        if (sat)
            return neg ? 16'h8000 : 16'h7FFF;
        else if (neg)
            return ~m + 16'd1;
        else
            return m;
    endfunction

    // Classify the exponent into its shift direction and distance, a flush to zero, or saturation.
    always_comb begin
        dec_k    = 4'd0;
        dec_left = 1'b0;
        dec_zero = 1'b0;
        dec_sat  = 1'b0;
        if (exp_r <= 5'd6) begin
            dec_zero = 1'b1;
        end else if (exp_r <= 5'd16) begin
            dec_k = 4'(5'd17 - exp_r);
        end else if (exp_r <= 5'd21) begin
            dec_left = 1'b1;
            dec_k    = 4'(exp_r - 5'd17);
        end else begin
            dec_sat = 1'b1;
        end
    end

    // Final signed result, consumed in FIX.
    always_comb begin
        fix_val = sign_saturate(sign_r, sat_r, mag);
    end

    // Conversion sequencer. Every output is registered, so the value an
    // output shows in a state is loaded on the edge that enters that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            done        <= 1'b1;
            WriteMem    <= 1'b0;
            DataAddress <= 8'd0;
            DataIn      <= 8'd0;
            fix_out     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RD_LO;
                        done        <= 1'b0;
                        DataAddress <= SRC_ADDR;
                    end
                end
                RD_LO: begin
                    mant_r[7:0] <= DataOut;
                    DataAddress <= SRC_ADDR + 8'd1;
                    state       <= RD_HI;
                end
                RD_HI: begin
                    sign_r      <= DataOut[7];
                    exp_r       <= DataOut[6:2];
                    mant_r[9:8] <= DataOut[1:0];
                    state       <= DECODE;
                end
                DECODE: begin
                    mag    <= dec_zero ? 16'd0 : {5'b00000, 1'b1, mant_r};
                    cnt    <= dec_k;
                    left_r <= dec_left;
                    sat_r  <= dec_sat;
                    state  <= (dec_k == 4'd0) ? FIX : SHIFT;
                end
                SHIFT: begin
                    // Bits shifted out on the right are discarded (truncation).
                    mag <= left_r ? (mag << 1) : (mag >> 1);
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= FIX;
                end
                FIX: begin
                    fix_out     <= fix_val;
                    DataIn      <= fix_val[7:0];
                    DataAddress <= DST_ADDR;
                    WriteMem    <= 1'b1;
                    state       <= WR_LO;
                end
                WR_LO: begin
                    DataIn      <= fix_out[15:8];
                    DataAddress <= DST_ADDR + 8'd1;
                    state       <= WR_HI;
                end
                WR_HI: begin
                    WriteMem <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_fix.sv
// Testbench for float_to_fix: directed and random float16 conversions
// through a small data memory, checked against an arithmetic reference.
module tb_float_to_fix;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [7:0]  DataAddress;
    logic        WriteMem;
    logic [7:0]  DataIn;
    logic [7:0]  DataOut;
    logic [15:0] fix_out;

    logic [7:0]  mem [0:255];
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_data;

    int checks   = 0;
    int failures = 0;

    float_to_fix #(.SRC_ADDR(8'd2), .DST_ADDR(8'd4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .done(done),
        .DataAddress(DataAddress),
        .WriteMem(WriteMem),
        .DataIn(DataIn),
        .DataOut(DataOut),
        .fix_out(fix_out)
    );

    always #5 clk = ~clk;

    assign DataOut = mem[DataAddress];

    // Single writer for the memory: DUT writes plus bench preloads.
    always @(posedge clk) begin
        if (WriteMem)
            mem[DataAddress] <= DataIn;
        if (ld_en)
            mem[ld_addr] <= ld_data;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference value: {1,mant} * 2^(e-17), truncated toward zero and clamped to int16.
    function automatic logic [15:0] ref_fix(input logic [15:0] f);
        int    e;
        real   r;
        int    t;
        e = int'(f[14:10]);
        r = real'(1024 + int'(f[9:0]));
        for (int i = 17; i < e; i++) r = r * 2.0;
        for (int i = e; i < 17; i++) r = r / 2.0;
        t = $rtoi(r);
        if (f[15]) t = -t;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return 16'(t);
    endfunction

    // Reference latency from start sampled to done high: 7 + shift distance.
    function automatic int ref_lat(input logic [15:0] f);
        int e;
        e = int'(f[14:10]);
        if (e >= 7 && e <= 16) return 7 + 17 - e;
        if (e >= 18 && e <= 21) return 7 + e - 17;
        return 7;
    endfunction

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk); #1;
        ld_en   = 1'b0;
    endtask

    task automatic prep(input logic [15:0] f);
        load(8'd2, f[7:0]);
        load(8'd3, f[15:8]);
        load(8'd4, 8'hA5);
        load(8'd5, 8'h5A);
    endtask

    task automatic convert(input logic [15:0] f, input logic [15:0] expv, input bit pulse_busy);
        int cycles;
        int wr;
        prep(f);
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 0;
        wr     = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (WriteMem === 1'b1) wr++;
            start = (pulse_busy && cycles == 3) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        check($sformatf("latency_%04h", f), 16'(cycles), 16'(ref_lat(f)));
        check($sformatf("writes_%04h", f), 16'(wr), 16'd2);
        check($sformatf("fix_out_%04h", f), fix_out, expv);
        check($sformatf("mem_lo_%04h", f), {8'h00, mem[4]}, {8'h00, expv[7:0]});
        check($sformatf("mem_hi_%04h", f), {8'h00, mem[5]}, {8'h00, expv[15:8]});
        if (pulse_busy) begin
            repeat (3) @(posedge clk);
            #1;
            check("busy_start_ignored_idle", {15'd0, done}, 16'd1);
        end
    endtask

    logic [15:0] dir_in  [10];
    logic [15:0] dir_exp [10];

    initial begin
        dir_in[0] = 16'h3C00; dir_exp[0] = 16'h0100;
        dir_in[1] = 16'hC100; dir_exp[1] = 16'hFD80;
        dir_in[2] = 16'h57FF; dir_exp[2] = 16'h7FF0;
        dir_in[3] = 16'h1C00; dir_exp[3] = 16'h0001;
        dir_in[4] = 16'h1800; dir_exp[4] = 16'h0000;
        dir_in[5] = 16'h8000; dir_exp[5] = 16'h0000;
        dir_in[6] = 16'h5BFF; dir_exp[6] = 16'h7FFF;
        dir_in[7] = 16'h7C00; dir_exp[7] = 16'h7FFF;
        dir_in[8] = 16'hD800; dir_exp[8] = 16'h8000;
        dir_in[9] = 16'hFC00; dir_exp[9] = 16'h8000;

        reset = 1'b1;
        start = 1'b0;
        ld_en = 1'b0;
        ld_addr = 8'd0;
        ld_data = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", {15'd0, done}, 16'd1);
        check("rst_writemem", {15'd0, WriteMem}, 16'd0);
        check("rst_addr", {8'h00, DataAddress}, 16'd0);
        check("rst_datain", {8'h00, DataIn}, 16'd0);
        check("rst_fix_out", fix_out, 16'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed conversions from the spec examples.
        for (int i = 0; i < 10; i++)
            convert(dir_in[i], dir_exp[i], 1'b0);

        // Start pulsed while busy must be ignored.
        convert(16'h1C00, 16'h0001, 1'b1);

        // Reset asserted in SHIFT aborts without writing.
        prep(16'h1C00);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_done", {15'd0, done}, 16'd1);
        check("abort_writemem", {15'd0, WriteMem}, 16'd0);
        check("abort_fix_out", fix_out, 16'd0);
        repeat (14) @(posedge clk);
        #1;
        check("abort_mem_lo", {8'h00, mem[4]}, 16'h00A5);
        check("abort_mem_hi", {8'h00, mem[5]}, 16'h005A);
        check("abort_idle", {15'd0, done}, 16'd1);
        convert(16'h3C00, 16'h0100, 1'b0);

        // Random conversions against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            logic [15:0] f;
            f = {1'($urandom), 5'($urandom_range(0, 31)), 10'($urandom)};
            convert(f, ref_fix(f), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/float_to_fix.md
Name: float_to_fix

Overview:
- Program 2 stage, directly downstream of the fix(8.8)-to-float16 converter.
- Reads a float16 word {sign, exp[4:0], mant[9:0]}, bias 15, that the upstream stage wrote to data memory.
- Converts it to two's-complement fix(8.8) with truncation toward zero (no rounding) and saturation.
- Writes the result back to data memory.
- Multi-cycle, serial-shift datapath with a start/done handshake toward the testbench.

Parameters:
- SRC_ADDR, 8'd2: address of float low byte; high byte at SRC_ADDR+1.
- DST_ADDR, 8'd4: address of fixed low byte; high byte at DST_ADDR+1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high; clock clk
- start  input  1  request a conversion; sampled only in IDLE
- done  output  1  high = idle/result valid; low = busy
- DataAddress  output  8  data memory address
- WriteMem  output  1  data memory write enable, one cycle per byte
- DataIn  output  8  write data to memory
- DataOut  input  8  memory read data, combinational from DataAddress
- fix_out  output  16  last result, debug/observation

Behaviour:
- Reset values: done=1, WriteMem=0, DataAddress=0, DataIn=0, fix_out=0, state=IDLE.
- Reset mid-operation: abort to IDLE next edge. No further writes. A byte already written stays in memory.
- FSM states and transitions:
  - IDLE: start=1 -> RD_LO, and done drops the next cycle. While busy, start is ignored.
  - RD_LO: addr=SRC_ADDR, latch DataOut as mant[7:0].
  - RD_HI: addr=SRC_ADDR+1, latch sign, exp, mant[9:8].
  - DECODE: classify exp e; load mag={1,mant} (11 bits) into a 16-bit register; load shift counter k.
  - SHIFT: one bit per cycle, k cycles; skipped when k=0.
  - FIX: saturate and apply sign; result -> fix_out.
  - WR_LO: addr=DST_ADDR, DataIn=fix[7:0], WriteMem=1.
  - WR_HI: addr=DST_ADDR+1, DataIn=fix[15:8], WriteMem=1.
  - DONE: done=1 -> IDLE. done stays high until the next start.
- Latency, start sampled to done high: 7+k cycles. k ranges 0..10.
- Arithmetic: fix = {1,mant} * 2^(e-17).
  - e in 7..16: right shift, k=17-e, shifted-out bits discarded (truncation).
  - e=17: k=0.
  - e in 18..21: left shift, k=e-17.
  - e<=6, including 0 and denormals: magnitude 0, k=0.
  - e>=22: saturate, k=0.
    - Positive, including +inf/NaN: 0x7FFF.
    - Negative: 0x8000.
    - e=22, mant=0, sign=1 is exactly -128, i.e. 0x8000. This is the upstream max-negative encoding.
- Sign: negative non-saturated result = two's complement of the 15-bit magnitude. Negative zero gives 0x0000.
- WriteMem is high only in WR_LO and WR_HI. DataAddress holds its last value elsewhere.
- start held high across DONE begins a new conversion from IDLE. There is no back-to-back skip.

Test Plan:
- 0x3C00 (1.0) -> mem[5:4]=0x0100; k=2; done high 9 cycles after start.
- 0xC100 (-2.5) -> 0xFD80; 0x57FF (e=21, max mantissa) -> 0x7FF0, k=4.
- 0x1C00 (2^-8) -> 0x0001, k=10, latency 17; 0x1800 -> 0x0000; 0x8000 (-0) -> 0x0000.
- 0x5BFF -> 0x7FFF; 0x7C00 (+inf) -> 0x7FFF; 0xD800 -> 0x8000; 0xFC00 -> 0x8000.
- Pulse start again while busy -> ignored. Exactly two WriteMem pulses per conversion; done low throughout.
- Assert reset during SHIFT -> next cycle done=1, WriteMem=0, DST bytes unchanged. A fresh start then converts correctly.
